// File: rtl/augment_pkg.sv
// Shared definitions for the image augmentation front end: default pixel
// geometry and the encoding of the image reader state machine.
package augment_pkg;

    localparam int PIXEL_WIDTH = 8;
    localparam int NUM_PIXELS  = 784;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } reader_state_e;

endpackage

// File: rtl/pixel_skid_buffer.sv
// Two-entry FIFO that absorbs BRAM read data so a downstream stall never
// loses a pixel that was already requested. Push and pop may occur in the
// same cycle; a push into a full buffer or a pop from an empty one is ignored.
module pixel_skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem0_q, mem0_d;
    logic [WIDTH-1:0] mem1_q, mem1_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             do_push;
    logic             do_pop;

    // Next-state of storage, pointers and occupancy.
    always_comb begin
        mem0_d   = mem0_q;
        mem1_d   = mem1_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        do_push  = push && (count_q != 2'd2);
        do_pop   = pop && (count_q != 2'd0);

        if (do_push) begin
            if (wr_ptr_q) begin
                mem1_d = push_data;
            end else begin
                mem0_d = push_data;
            end
            wr_ptr_d = ~wr_ptr_q;
        end

        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
    end

    // Storage registers; clearing the data makes the head read 0 after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem0_q   <= '0;
            mem1_q   <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem0_q   <= mem0_d;
            mem1_q   <= mem1_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = rd_ptr_q ? mem1_q : mem0_q;
    assign count = count_q;

endmodule

// File: rtl/image_reader.sv
// Streams a batch of images out of a source BRAM, one pixel per cycle, into
// the augmentation pipeline. Reads are credit-limited against a 2-entry skid
// buffer so that a downstream stall (interrupt) never drops or repeats pixels.
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | waiting for start; num_images==0 only produces a done pulse
// FETCH  | issuing BRAM reads whenever the skid buffer has credit
// DRAIN  | last read issued; waiting for buffer and outstanding read to empty
module image_reader #(
    parameter int          ADDR_WIDTH  = 16,
    parameter int          PIXEL_WIDTH = augment_pkg::PIXEL_WIDTH,
    parameter int          NUM_PIXELS  = augment_pkg::NUM_PIXELS,
    parameter int          CNT_WIDTH   = 8,
    parameter int unsigned BRAM_BASE   = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [CNT_WIDTH-1:0]   num_images,
    output logic [ADDR_WIDTH-1:0]  bram_addr,
    output logic                   bram_en,
    input  logic [PIXEL_WIDTH-1:0] bram_data,
    output logic [PIXEL_WIDTH-1:0] pixel_out,
    output logic                   pixel_out_valid,
    input  logic                   interrupt,
    output logic                   busy,
    output logic                   done
);

    import augment_pkg::*;

    localparam int                    PIX_IDX_W = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
    localparam logic [PIX_IDX_W-1:0]  LAST_PIX  = PIX_IDX_W'(NUM_PIXELS - 1);
    localparam logic [ADDR_WIDTH-1:0] BASE_ADDR = ADDR_WIDTH'(BRAM_BASE);

    reader_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [PIX_IDX_W-1:0]   pix_idx_q, pix_idx_d;
    logic [CNT_WIDTH-1:0]   img_cnt_q, img_cnt_d;
    logic [CNT_WIDTH-1:0]   num_img_q, num_img_d;
    logic                   rd_pend_q, rd_pend_d;
    logic                   zero_done_q, zero_done_d;

    logic                   drain_done;
    logic                   last_read;
    logic                   credit_ok;
    logic                   fifo_pop;
    logic [1:0]             fifo_count;
    logic [2:0]             occ_after_pop;

    // A pixel leaves whenever the buffer holds one and downstream is not stalled.
    always_comb begin
        pixel_out_valid = (fifo_count != 2'd0) && !interrupt;
        fifo_pop        = pixel_out_valid;
    end

    // Read credit: buffered plus in-flight pixels, less the one leaving now,
    // must stay below the buffer depth so the returning data always fits.
    always_comb begin
        occ_after_pop = {1'b0, fifo_count} + {2'b00, rd_pend_q} - {2'b00, fifo_pop};
        credit_ok     = (occ_after_pop < 3'd2);
        bram_en       = (state_q == ST_FETCH) && credit_ok;
        last_read     = (pix_idx_q == LAST_PIX) && (img_cnt_q == (num_img_q - CNT_WIDTH'(1)));
    end

    // Batch sequencing, address generation and pixel/image counting.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        pix_idx_d   = pix_idx_q;
        img_cnt_d   = img_cnt_q;
        num_img_d   = num_img_q;
        zero_done_d = 1'b0;
        drain_done  = 1'b0;
        rd_pend_d   = bram_en;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (num_images != '0) begin
                        state_d   = ST_FETCH;
                        num_img_d = num_images;
                        addr_d    = BASE_ADDR;
                        pix_idx_d = '0;
                        img_cnt_d = '0;
                    end else begin
                        zero_done_d = 1'b1;
                    end
                end
            end

            ST_FETCH: begin
                if (bram_en) begin
                    addr_d = addr_q + ADDR_WIDTH'(1);
                    if (pix_idx_q == LAST_PIX) begin
                        pix_idx_d = '0;
                        img_cnt_d = img_cnt_q + CNT_WIDTH'(1);
                    end else begin
                        pix_idx_d = pix_idx_q + PIX_IDX_W'(1);
                    end
                    if (last_read) begin
                        state_d = ST_DRAIN;
                    end
                end
            end

            ST_DRAIN: begin
                if ((fifo_count == 2'd0) && !rd_pend_q) begin
                    state_d    = ST_IDLE;
                    drain_done = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control registers; clearing rd_pend on reset discards any read in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            addr_q      <= BASE_ADDR;
            pix_idx_q   <= '0;
            img_cnt_q   <= '0;
            num_img_q   <= '0;
            rd_pend_q   <= 1'b0;
            zero_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            pix_idx_q   <= pix_idx_d;
            img_cnt_q   <= img_cnt_d;
            num_img_q   <= num_img_d;
            rd_pend_q   <= rd_pend_d;
            zero_done_q <= zero_done_d;
        end
    end

    pixel_skid_buffer #(
        .WIDTH (PIXEL_WIDTH)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .push      (rd_pend_q),
        .push_data (bram_data),
        .pop       (fifo_pop),
        .head      (pixel_out),
        .count     (fifo_count)
    );

    // Status outputs.
    always_comb begin
        bram_addr = addr_q;
        busy      = (state_q != ST_IDLE);
        done      = drain_done || zero_done_q;
    end

endmodule

// File: tb/tb_image_reader.sv
// Directed bench for image_reader: full batches, stalls, ignored restart,
// zero-length batch, mid-batch reset and a toggling stall.
module tb_image_reader;

    localparam int NP = 784;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  num_images;
    logic [15:0] bram_addr;
    logic        bram_en;
    logic [7:0]  bram_data = 8'h00;
    logic [7:0]  pixel_out;
    logic        pixel_out_valid;
    logic        interrupt;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    image_reader dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .num_images      (num_images),
        .bram_addr       (bram_addr),
        .bram_en         (bram_en),
        .bram_data       (bram_data),
        .pixel_out       (pixel_out),
        .pixel_out_valid (pixel_out_valid),
        .interrupt       (interrupt),
        .busy            (busy),
        .done            (done)
    );

    function automatic logic [7:0] bram_val(input logic [15:0] a);
        return a[7:0] * 8'd37 + a[15:8] + 8'd11;
    endfunction

    // Source BRAM: one-cycle read latency.
    always @(posedge clk) begin
        if (bram_en) bram_data <= bram_val(bram_addr);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
            chk("post_busy", busy, 0);
            chk("post_done", done, 0);
            chk("post_en", bram_en, 0);
            chk("post_valid", pixel_out_valid, 0);
        end
    endtask

    // mode 0: no stall, 1: 5-cycle stall at pixel 100, 2: stall toggles
    // every cycle, 3: second start (num_images=3) at cycle 10.
    task automatic run_batch(input int n, input int mode, input int exp_pix);
        int cyc, rd, px, stall, first_valid, last_valid;
        bit fin;
        cyc = 0; rd = 0; px = 0; stall = 5; first_valid = -1; last_valid = -1; fin = 0;
        @(negedge clk);
        start = 1'b1;
        num_images = 8'(n);
        interrupt = 1'b0;
        #1;
        chk("start_busy", busy, 0);
        chk("start_en", bram_en, 0);
        while (!fin && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            case (mode)
                1: begin
                    interrupt = (px >= 100) && (stall > 0);
                    if (interrupt) stall--;
                end
                2: interrupt = (cyc % 2) == 1;
                3: if (cyc == 10) begin
                    start = 1'b1;
                    num_images = 8'd3;
                end
                default: interrupt = 1'b0;
            endcase
            #1;
            chk("busy", busy, 1);
            chk("gate", pixel_out_valid & interrupt, 0);
            if (mode == 2) chk("occ", dut.fifo_count <= 2'd2, 1);
            if (bram_en) begin
                chk("addr", bram_addr, 32'(rd));
                rd++;
            end
            if (pixel_out_valid) begin
                if (px == 0) first_valid = cyc;
                chk("pix", pixel_out, bram_val(16'(px)));
                last_valid = cyc;
                px++;
            end
            if (done) begin
                chk("done_px", px, exp_pix);
                chk("done_lat", cyc, last_valid + 1);
                fin = 1;
            end
        end
        interrupt = 1'b0;
        start = 1'b0;
        chk("finished", fin, 1);
        chk("reads", rd, exp_pix);
        if (mode == 0 || mode == 3) begin
            chk("first_valid", first_valid, 3);
            chk("continuous", last_valid, 3 + exp_pix - 1);
        end
        if (mode == 1) chk("stall_span", last_valid, 3 + exp_pix + 5 - 1);
        idle_cycles(5);
    endtask

    task automatic zero_batch();
        @(negedge clk);
        start = 1'b1;
        num_images = 8'd0;
        #1;
        chk("zero_start_done", done, 0);
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("zero_done", done, 1);
        chk("zero_busy", busy, 0);
        chk("zero_en", bram_en, 0);
        idle_cycles(4);
    endtask

    task automatic reset_abort();
        int cyc, px;
        cyc = 0; px = 0;
        @(negedge clk);
        start = 1'b1;
        num_images = 8'd1;
        #1;
        while (px < 400 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            #1;
            chk("abort_done", done, 0);
            if (pixel_out_valid) begin
                chk("abort_pix", pixel_out, bram_val(16'(px)));
                px++;
            end
        end
        chk("abort_reached", px, 400);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_addr", bram_addr, 0);
        chk("rst_en", bram_en, 0);
        chk("rst_pix", pixel_out, 0);
        chk("rst_valid", pixel_out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        idle_cycles(5);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        num_images = 8'd0;
        interrupt = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("init_addr", bram_addr, 0);
        chk("init_en", bram_en, 0);
        chk("init_pix", pixel_out, 0);
        chk("init_valid", pixel_out_valid, 0);
        chk("init_busy", busy, 0);
        chk("init_done", done, 0);
        chk("bram_val0", bram_val(16'd0), 11);
        reset = 1'b0;

        zero_batch();
        run_batch(2, 0, 2 * NP);
        run_batch(1, 1, NP);
        run_batch(1, 3, NP);
        reset_abort();
        run_batch(1, 0, NP);
        run_batch(1, 2, NP);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
